// File: rtl/mil_tx_queued.sv
// Queued MIL-STD-1553 Manchester word transmitter: words wait in a FIFO until the arbiter grants the bus.
// Optional macro MIL_TX_PARITY_INJECT_EN adds inject_parity, which forces even parity on the word popped with it.
module mil_tx_queued #(
    parameter int DEPTH   = 8,
    parameter int CLK_DIV = 25,
    parameter int GAP_HB  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [1:0]                 push_type,
    input  logic [15:0]                push_data,
    output logic                       push_ready,
    input  logic                       grant,
`ifdef MIL_TX_PARITY_INJECT_EN
    input  logic                       inject_parity,
`endif
    output logic                       lineP,
    output logic                       lineN,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int AW      = $clog2(DEPTH);
    localparam int DW      = $clog2(CLK_DIV + 1);
    localparam int WORD_HB = 40;
    localparam int HB_MAX  = (GAP_HB > WORD_HB) ? GAP_HB : WORD_HB;
    localparam int HW      = $clog2(HB_MAX);
    localparam logic [1:0] WDATA = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_BITS, S_PAR, S_GAP} state_t;

    // Entry layout: {uses data sync, payload}
    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    state_t        state_q, state_d;
    logic [HW-1:0] hb_q, hb_d, hb_nx;
    logic [DW-1:0] div_q, div_d;
    logic [15:0]   word_q, word_d;
    logic          is_data_q, is_data_d;
    logic          par_q, par_d;
    logic [1:0]    line_q, line_d;
    logic          busy_q, busy_d;

    logic [16:0]   head;
    logic          head_par;
    logic          fifo_empty, push_ok, pop, start, last_div;

    // {lineP, lineN} for half-bit idx (0..39) of a word
    function automatic logic [1:0] hb_drive(input logic [5:0] idx, input logic is_data,
                                            input logic [15:0] w, input logic par);
        logic       lvl;
        logic [5:0] off;
        logic [3:0] bi;
        lvl = 1'b0;
        off = idx - 6'd6;
        bi  = 4'd15 - off[4:1];
        if (idx < 6'd6)
            lvl = (idx < 6'd3) ^ is_data;
        else if (idx < 6'd38)
            lvl = w[bi] ^ off[0];
        else
            lvl = par ^ idx[0];
        return lvl ? 2'b10 : 2'b01;
    endfunction

    assign head       = mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
`ifdef MIL_TX_PARITY_INJECT_EN
    assign head_par   = ~(^head[15:0]) ^ inject_parity;
`else
    assign head_par   = ~(^head[15:0]);
`endif

    always_comb begin
        state_d   = state_q;
        hb_d      = hb_q;
        div_d     = div_q;
        word_d    = word_q;
        is_data_d = is_data_q;
        par_d     = par_q;
        line_d    = line_q;
        start     = 1'b0;
        hb_nx     = hb_q + HW'(1);
        last_div  = (div_q == DW'(CLK_DIV - 1));

        case (state_q)
            S_IDLE: start = grant && !fifo_empty;
            S_SYNC, S_BITS, S_PAR: begin
                if (!last_div) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d = '0;
                    if (hb_q == HW'(WORD_HB - 1)) begin
                        // Back-to-back words form one contiguous message
                        if (grant && !fifo_empty) begin
                            start = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            hb_d    = '0;
                            line_d  = 2'b00;
                        end
                    end else begin
                        hb_d   = hb_nx;
                        line_d = hb_drive(hb_nx[5:0], is_data_q, word_q, par_q);
                        if (hb_nx == HW'(6))
                            state_d = S_BITS;
                        else if (hb_nx == HW'(38))
                            state_d = S_PAR;
                    end
                end
            end
            S_GAP: begin
                if (!last_div) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d = '0;
                    if (hb_q == HW'(GAP_HB - 1)) begin
                        state_d = S_IDLE;
                        hb_d    = '0;
                    end else begin
                        hb_d = hb_nx;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d   = S_SYNC;
            hb_d      = '0;
            div_d     = '0;
            word_d    = head[15:0];
            is_data_d = head[16];
            par_d     = head_par;
            line_d    = head[16] ? 2'b01 : 2'b10;
        end
        busy_d = (state_d != S_IDLE);

        pop      = start;
        push_ok  = push_valid && (count_q != CW'(DEPTH));
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_q] <= {push_type == WDATA, push_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hb_q      <= '0;
            div_q     <= '0;
            word_q    <= '0;
            is_data_q <= 1'b0;
            par_q     <= 1'b0;
            line_q    <= 2'b00;
            busy_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            hb_q      <= hb_d;
            div_q     <= div_d;
            word_q    <= word_d;
            is_data_q <= is_data_d;
            par_q     <= par_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign lineP      = line_q[1];
    assign lineN      = line_q[0];
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign push_ready = (count_q != CW'(DEPTH));
endmodule

// File: tb/tb_mil_tx_queued.sv
// Bench for mil_tx_queued: a word/queue-level model checked every cycle, plus literal line patterns and counts.
module tb_mil_tx_queued;
    // DEPTH=4 so the full-FIFO case is reachable; timing parameters stay at their defaults.
    localparam int DEPTH    = 4;
    localparam int CLK_DIV  = 25;
    localparam int GAP_HB   = 8;
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int WORD_CYC = 40 * CLK_DIV;
    localparam int GAP_CYC  = GAP_HB * CLK_DIV;
    localparam logic [1:0] WCOMMAND = 2'd0, WSTATUS = 2'd1, WDATA = 2'd2;
    // lineP level per half-bit, first half-bit in the MSB
    localparam logic [39:0] P_CMD_02A1  = 40'b111000_01010101_01011001_10011001_01010110_10;
    localparam logic [39:0] P_DAT_02A1  = 40'b000111_01010101_01011001_10011001_01010110_10;
    localparam logic [39:0] P_DAT_8001  = 40'b000111_10010101_01010101_01010101_01010110_10;
    localparam logic [39:0] P_CMD_02A1I = 40'b111000_01010101_01011001_10011001_01010110_01;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_valid = 1'b0;
    logic [1:0]    push_type = 2'd0;
    logic [15:0]   push_data = 16'h0;
    logic          grant = 1'b0;
    logic          inject_parity = 1'b0;
    logic          push_ready, lineP, lineN, busy;
    logic [CW-1:0] fifo_count;

    int n_chk = 0;
    int n_err = 0;

    mil_tx_queued #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .GAP_HB(GAP_HB)) dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_type(push_type),
        .push_data(push_data), .push_ready(push_ready), .grant(grant),
`ifdef MIL_TX_PARITY_INJECT_EN
        .inject_parity(inject_parity),
`endif
        .lineP(lineP), .lineN(lineN), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [16:0] mq[$];
    int          m_mode = 0;   // 0 idle, 1 sending a word, 2 inter-message gap
    int          m_cyc = 0;
    logic [39:0] m_hb = '0;
    bit          m_valid = 1'b0;

    function automatic logic [39:0] word_pattern(input logic is_data, input logic [15:0] d, input logic inj);
        logic [39:0] r;
        logic        par;
        int          k;
        r = '0;
        k = 39;
        for (int i = 0; i < 6; i++) begin
            r[k] = (i < 3) ? !is_data : is_data;
            k--;
        end
        for (int b = 15; b >= 0; b--) begin
            r[k] = d[b];
            r[k-1] = !d[b];
            k -= 2;
        end
        par = (($countones(d) % 2) == 0) ^ inj;
        r[1] = par;
        r[0] = !par;
        return r;
    endfunction

    initial begin : model
        bit          accept, do_pop;
        logic [16:0] e;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_mode  = 0;
                m_cyc   = 0;
                m_valid = 1'b1;
            end else begin
                accept = push_valid && (mq.size() < DEPTH);
                do_pop = 1'b0;
                if (m_mode == 0) begin
                    do_pop = grant && (mq.size() > 0);
                end else if (m_mode == 1) begin
                    m_cyc++;
                    if (m_cyc == WORD_CYC) begin
                        if (grant && (mq.size() > 0)) do_pop = 1'b1;
                        else begin m_mode = 2; m_cyc = 0; end
                    end
                end else begin
                    m_cyc++;
                    if (m_cyc == GAP_CYC) begin m_mode = 0; m_cyc = 0; end
                end
                if (do_pop) begin
                    e = mq.pop_front();
                    m_hb = word_pattern(e[16], e[15:0], inject_parity);
                    m_mode = 1;
                    m_cyc = 0;
                end
                if (accept) mq.push_back({push_type == WDATA, push_data});
            end
        end
    end

    initial begin : compare
        logic [6:0] exp_v, act_v;
        logic       ep;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                ep = (m_mode == 1) ? m_hb[39 - m_cyc / CLK_DIV] : 1'b0;
                exp_v = {ep, (m_mode == 1) ? !ep : 1'b0, m_mode != 0, CW'(mq.size()), mq.size() != DEPTH};
                act_v = {lineP, lineN, busy, fifo_count, push_ready};
                n_chk++;
                if (act_v !== exp_v) begin
                    n_err++;
                    $display("FAIL cycle_compare t=%0t {P,N,busy,count,ready} got %b expected %b", $time, act_v, exp_v);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    logic rec_p [5000];
    logic rec_n [5000];
    logic rec_b [5000];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [15:0] d);
        push_valid = 1'b1;
        push_type  = t;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rec_p[i] = lineP;
            rec_n[i] = lineN;
            rec_b[i] = busy;
        end
    endtask

    function automatic int first_active(input int n);
        for (int i = 0; i < n; i++)
            if (rec_p[i] || rec_n[i]) return i;
        return -1;
    endfunction

    function automatic int count_active(input int n);
        int c = 0;
        for (int i = 0; i < n; i++)
            if (rec_p[i] || rec_n[i]) c++;
        return c;
    endfunction

    function automatic int count_busy(input int n);
        int c = 0;
        for (int i = 0; i < n; i++)
            if (rec_b[i]) c++;
        return c;
    endfunction

    function automatic logic [39:0] extract(input int s);
        logic [39:0] r;
        int b;
        b = (s < 0) ? 0 : s;
        for (int h = 0; h < 40; h++)
            r[39 - h] = rec_p[b + h * CLK_DIV + CLK_DIV / 2];
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : main
        int s;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_count", fifo_count, 0);
        chk("reset_ready", push_ready, 1);
        chk("reset_lines", {lineP, lineN}, 0);
        chk("reset_busy", busy, 0);

        // Single command word with grant already high
        grant = 1'b1;
        push(WCOMMAND, 16'h02A1);
        record(1400);
        s = first_active(1400);
        chk("single_first_halfbit", s, 1);
        chk("single_pattern", extract(s), P_CMD_02A1);
        chk("single_active_cycles", count_active(1400), WORD_CYC);
        chk("single_busy_cycles", count_busy(1400), WORD_CYC + GAP_CYC);
        grant = 1'b0;

        // Command then data queued, grant arrives later: contiguous message
        push(WCOMMAND, 16'h02A1);
        push(WDATA, 16'h02A1);
        repeat (298) tick();
        chk("queued_count", fifo_count, 2);
        grant = 1'b1;
        record(2700);
        s = first_active(2700);
        chk("msg_first_halfbit", s, 1);
        chk("msg_word1_pattern", extract(s), P_CMD_02A1);
        chk("msg_word2_pattern", extract(s + WORD_CYC), P_DAT_02A1);
        chk("msg_active_cycles", count_active(2700), 2 * WORD_CYC);
        chk("msg_busy_cycles", count_busy(2700), 2 * WORD_CYC + GAP_CYC);
        grant = 1'b0;

        // Overfill the FIFO: fifth push is dropped
        push(WCOMMAND, 16'h1234);
        push(WDATA, 16'hFFFF);
        push(WSTATUS, 16'h0000);
        push(WDATA, 16'h8001);
        push(WCOMMAND, 16'hBEEF);
        @(negedge clk);
        chk("full_count", fifo_count, DEPTH);
        chk("full_ready", push_ready, 0);
        grant = 1'b1;
        record(4400);
        s = first_active(4400);
        chk("full_first_halfbit", s, 0);
        chk("full_active_cycles", count_active(4400), 4 * WORD_CYC);
        chk("full_word4_pattern", extract(s + 3 * WORD_CYC), P_DAT_8001);
        chk("full_busy_cycles", count_busy(4400), 4 * WORD_CYC + GAP_CYC);
        grant = 1'b0;

        // Push and pop on the same edge, then grant dropped mid-word
        push(WCOMMAND, 16'hA5A5);
        push_valid = 1'b1;
        push_type  = WDATA;
        push_data  = 16'h5A5A;
        grant      = 1'b1;
        tick();
        push_valid = 1'b0;
        @(negedge clk);
        chk("pushpop_count", fifo_count, 1);
        repeat (250) tick();
        grant = 1'b0;
        record(2000);
        chk("drop_active_cycles", count_active(2000), WORD_CYC - 250);
        chk("drop_idle_busy", rec_b[1999], 0);
        chk("drop_waiting_count", fifo_count, 1);
        grant = 1'b1;
        record(1300);
        chk("resume_first_halfbit", first_active(1300), 0);
        chk("resume_active_cycles", count_active(1300), WORD_CYC);
        grant = 1'b0;

        // Reset in the middle of BITS, with a push in the reset cycle
        push(WCOMMAND, 16'hFFFF);
        push(WDATA, 16'h0F0F);
        grant = 1'b1;
        repeat (400) tick();
        rst        = 1'b1;
        push_valid = 1'b1;
        push_type  = WDATA;
        push_data  = 16'h1111;
        tick();
        rst        = 1'b0;
        push_valid = 1'b0;
        @(negedge clk);
        chk("midreset_lines", {lineP, lineN}, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_count", fifo_count, 0);
        chk("midreset_ready", push_ready, 1);
        repeat (20) tick();
        grant = 1'b0;

`ifdef MIL_TX_PARITY_INJECT_EN
        grant = 1'b1;
        inject_parity = 1'b1;
        push(WCOMMAND, 16'h02A1);
        record(1100);
        chk("inject_pattern", extract(first_active(1100)), P_CMD_02A1I);
        inject_parity = 1'b0;
        grant = 1'b0;
        repeat (250) tick();
`endif

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
